video_stream_rx: RTL

Synthesizable sink for the board's parallel HDMI-style video stream (pixel clock, DE, HSYNC, VSYNC, 24-bit RGB): the receiving end of the stream produced by the video source/generator. It registers the incoming pixels and annotates each one with x/y coordinates and frame/line markers. It also measures the stream timing (active and total sizes) and reports lock once the timing is stable. It sits between the video input pins (or the simulation source) and downstream processing IPs.

---
 rtl/video_stream_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/video_stream_rx.sv
// Receiver for a parallel DE/HS/VS/RGB video stream: registers pixels, tags them with
// coordinates and frame/line markers, measures active/total timing and reports lock.
module video_stream_rx #(
  parameter int SYNC_POL = 1,
  parameter int CW       = 11
) (
  input  logic          hdmi_clk,
  input  logic          rst,
  input  logic          hdmi_de,
  input  logic          hdmi_hs,
  input  logic          hdmi_vs,
  input  logic [7:0]    hdmi_r,
  input  logic [7:0]    hdmi_g,
  input  logic [7:0]    hdmi_b,
  output logic          pix_valid,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_end,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] v_total,
  output logic          meas_valid,
  output logic          locked,
  output logic          sync_err
);

  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + ONE;
  endfunction

  // stage 1 (input register) and stage 2 (edge stage)
  logic          de1_q, hs1_q, vs1_q, de1_d, hs1_d, vs1_d;
  logic [7:0]    r1_q, g1_q, b1_q, r1_d, g1_d, b1_d;
  logic          de2_q, hs2_q, vs2_q, fs2_q, de2_d, hs2_d, vs2_d, fs2_d;
  logic [7:0]    r2_q, g2_q, b2_q, r2_d, g2_d, b2_d;
  logic [CW-1:0] x2_q, y2_q, x2_d, y2_d;
  // output stage
  logic          pv_q, fs_q, le_q, pv_d, fs_d, le_d;
  logic [7:0]    pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;
  logic [CW-1:0] px_q, py_q, px_d, py_d;
  // counters and running measurements
  logic [CW-1:0] hcnt_q, xcnt_q, ycnt_q, lcnt_q, htot_cur_q, hact_cur_q;
  logic [CW-1:0] hcnt_d, xcnt_d, ycnt_d, lcnt_d, htot_cur_d, hact_cur_d;
  logic          armed_q, armed_d, err_q, err_d, seen_vs_q, seen_vs_d;
  // latched measurements
  logic [CW-1:0] h_active_q, h_total_q, v_active_q, v_total_q;
  logic [CW-1:0] h_active_d, h_total_d, v_active_d, v_total_d;
  logic          mv_q, mv_d, locked_q, locked_d;

  logic hs_rise, vs_rise, de_fall, take, same;

  assign hs_rise = hs1_q & ~hs2_q;
  assign vs_rise = vs1_q & ~vs2_q;
  assign de_fall = de2_q & ~de1_q;

  // Pixel pipeline, coordinate counters and sync error flag.
  always_comb begin
    de1_d = hdmi_de;
    hs1_d = (SYNC_POL != 0) ? hdmi_hs : ~hdmi_hs;
    vs1_d = (SYNC_POL != 0) ? hdmi_vs : ~hdmi_vs;
    r1_d  = hdmi_r;
    g1_d  = hdmi_g;
    b1_d  = hdmi_b;

    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    r2_d  = r1_q;
    g2_d  = g1_q;
    b2_d  = b1_q;
    x2_d  = de1_q ? xcnt_q : x2_q;
    y2_d  = de1_q ? ycnt_q : y2_q;
    fs2_d = de1_q & armed_q & (ycnt_q == ZERO);

    // Stage 1 already holds the next sample, so the last pixel of a line is known here.
    pv_d = de2_q;
    pr_d = r2_q;
    pg_d = g2_q;
    pb_d = b2_q;
    px_d = de2_q ? x2_q : ZERO;
    py_d = de2_q ? y2_q : ZERO;
    fs_d = de2_q & fs2_q;
    le_d = de2_q & ~de1_q;

    hcnt_d     = hs_rise ? ZERO : sat_inc(hcnt_q);
    htot_cur_d = hs_rise ? sat_inc(hcnt_q) : htot_cur_q;
    xcnt_d     = de1_q ? sat_inc(xcnt_q) : ZERO;
    hact_cur_d = de_fall ? xcnt_q : hact_cur_q;

    if (vs_rise) begin
      ycnt_d = ZERO;
    end else if (de_fall) begin
      ycnt_d = sat_inc(ycnt_q);
    end else begin
      ycnt_d = ycnt_q;
    end

    // A line starting together with the frame belongs to the new frame.
    if (vs_rise) begin
      lcnt_d = hs_rise ? ONE : ZERO;
    end else if (hs_rise) begin
      lcnt_d = sat_inc(lcnt_q);
    end else begin
      lcnt_d = lcnt_q;
    end

    if (vs_rise) begin
      armed_d = 1'b1;
    end else if (de1_q && (ycnt_q == ZERO)) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    err_d = err_q | (de1_q & (hs1_q | vs1_q));
  end

  // Measurement latch and lock decision at each frame boundary.
  always_comb begin
    take      = vs_rise & seen_vs_q;
    seen_vs_d = seen_vs_q | vs_rise;
    same      = (htot_cur_q == h_total_q) && (hact_cur_q == h_active_q) &&
                (ycnt_q == v_active_q) && (lcnt_q == v_total_q);
    if (take) begin
      h_total_d  = htot_cur_q;
      h_active_d = hact_cur_q;
      v_active_d = ycnt_q;
      v_total_d  = lcnt_q;
      mv_d       = 1'b1;
      locked_d   = same && (hact_cur_q != ZERO) && (ycnt_q != ZERO);
    end else begin
      h_total_d  = h_total_q;
      h_active_d = h_active_q;
      v_active_d = v_active_q;
      v_total_d  = v_total_q;
      mv_d       = 1'b0;
      locked_d   = locked_q;
    end
  end

  // All state registers.
  always_ff @(posedge hdmi_clk or posedge rst) begin
    if (rst) begin
      de1_q <= 1'b0;  hs1_q <= 1'b0;  vs1_q <= 1'b0;
      r1_q  <= 8'd0;  g1_q  <= 8'd0;  b1_q  <= 8'd0;
      de2_q <= 1'b0;  hs2_q <= 1'b0;  vs2_q <= 1'b0;  fs2_q <= 1'b0;
      r2_q  <= 8'd0;  g2_q  <= 8'd0;  b2_q  <= 8'd0;
      x2_q  <= ZERO;  y2_q  <= ZERO;
      pv_q  <= 1'b0;  fs_q  <= 1'b0;  le_q  <= 1'b0;
      pr_q  <= 8'd0;  pg_q  <= 8'd0;  pb_q  <= 8'd0;
      px_q  <= ZERO;  py_q  <= ZERO;
      hcnt_q <= ZERO; xcnt_q <= ZERO; ycnt_q <= ZERO; lcnt_q <= ZERO;
      htot_cur_q <= ZERO; hact_cur_q <= ZERO;
      armed_q <= 1'b0; err_q <= 1'b0; seen_vs_q <= 1'b0;
      h_active_q <= ZERO; h_total_q <= ZERO; v_active_q <= ZERO; v_total_q <= ZERO;
      mv_q <= 1'b0; locked_q <= 1'b0;
    end else begin
      de1_q <= de1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
      r1_q  <= r1_d;  g1_q  <= g1_d;  b1_q  <= b1_d;
      de2_q <= de2_d; hs2_q <= hs2_d; vs2_q <= vs2_d; fs2_q <= fs2_d;
      r2_q  <= r2_d;  g2_q  <= g2_d;  b2_q  <= b2_d;
      x2_q  <= x2_d;  y2_q  <= y2_d;
      pv_q  <= pv_d;  fs_q  <= fs_d;  le_q  <= le_d;
      pr_q  <= pr_d;  pg_q  <= pg_d;  pb_q  <= pb_d;
      px_q  <= px_d;  py_q  <= py_d;
      hcnt_q <= hcnt_d; xcnt_q <= xcnt_d; ycnt_q <= ycnt_d; lcnt_q <= lcnt_d;
      htot_cur_q <= htot_cur_d; hact_cur_q <= hact_cur_d;
      armed_q <= armed_d; err_q <= err_d; seen_vs_q <= seen_vs_d;
      h_active_q <= h_active_d; h_total_q <= h_total_d;
      v_active_q <= v_active_d; v_total_q <= v_total_d;
      mv_q <= mv_d; locked_q <= locked_d;
    end
  end

  assign pix_valid   = pv_q;
  assign pix_r       = pr_q;
  assign pix_g       = pg_q;
  assign pix_b       = pb_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;
  assign frame_start = fs_q;
  assign line_end    = le_q;
  assign h_active    = h_active_q;
  assign h_total     = h_total_q;
  assign v_active    = v_active_q;
  assign v_total     = v_total_q;
  assign meas_valid  = mv_q;
  assign locked      = locked_q;
  assign sync_err    = err_q;

endmodule
